// File: rtl/restoring_divider_ctrl_pkg.sv
// Shared constants for the restoring divider controller: FSM encodings and default width.
package restoring_divider_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/restoring_divider_ctrl_if.sv
// Request/result bundle between a requester (master) and the divider controller (slave).
interface restoring_divider_ctrl_if
    import restoring_divider_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/restoring_divider_ctrl_sub_unit.sv
// Ripple-carry subtractor a - b built as a + ~b + 1; no_borrow is the final carry (a >= b).
module sub_unit #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             no_borrow
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic bn;
        assign bn           = ~b[i];
        assign diff[i]      = a[i] ^ bn ^ carry[i];
        assign carry[i + 1] = (a[i] & bn) | (carry[i] & (a[i] ^ bn));
    end

    assign no_borrow = carry[WIDTH];

endmodule

// File: rtl/restoring_divider_ctrl.sv
// Multi-cycle unsigned restoring divider: one shared subtractor, one quotient bit per clock.
module restoring_divider_ctrl
    import restoring_divider_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    restoring_divider_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [1:0]       state, state_nxt;
    logic [WIDTH:0]   r, r_nxt;
    logic [WIDTH-1:0] q, q_nxt;
    logic [WIDTH-1:0] d, d_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [WIDTH-1:0] quotient, quotient_nxt;
    logic [WIDTH-1:0] remainder, remainder_nxt;
    logic             dbz, dbz_nxt;
    logic             busy, done;

    logic [WIDTH:0]   s, diff, r_step;
    logic             no_borrow;
    logic             r_msb_unused;

    // Shift the next dividend bit into the partial remainder and trial-subtract the divisor.
    assign s            = {r[WIDTH-1:0], q[WIDTH-1]};
    assign r_step       = no_borrow ? diff : s;
    assign r_msb_unused = r[WIDTH];

    sub_unit #(
        .WIDTH(WIDTH + 1)
    ) u_sub (
        .a        (s),
        .b        ({1'b0, d}),
        .diff     (diff),
        .no_borrow(no_borrow)
    );

    // Next-state and datapath update.
    always_comb begin
        state_nxt     = state;
        r_nxt         = r;
        q_nxt         = q;
        d_nxt         = d;
        count_nxt     = count;
        quotient_nxt  = quotient;
        remainder_nxt = remainder;
        dbz_nxt       = dbz;

        case (state)
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        r_nxt     = '0;
                        q_nxt     = bus.dividend;
                        d_nxt     = bus.divisor;
                        count_nxt = CNT_W'(WIDTH - 1);
                        dbz_nxt   = 1'b0;
                        state_nxt = ST_RUN;
                    end else begin
                        quotient_nxt  = '1;
                        remainder_nxt = bus.dividend;
                        dbz_nxt       = 1'b1;
                        state_nxt     = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                r_nxt = r_step;
                q_nxt = {q[WIDTH-2:0], no_borrow};
                if (count == '0) begin
                    quotient_nxt  = {q[WIDTH-2:0], no_borrow};
                    remainder_nxt = r_step[WIDTH-1:0];
                    state_nxt     = ST_DONE;
                end else begin
                    count_nxt = count - CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            r         <= '0;
            q         <= '0;
            d         <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            r         <= r_nxt;
            q         <= q_nxt;
            d         <= d_nxt;
            count     <= count_nxt;
            quotient  <= quotient_nxt;
            remainder <= remainder_nxt;
            dbz       <= dbz_nxt;
            busy      <= (state_nxt == ST_RUN);
            done      <= (state_nxt == ST_DONE);
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = dbz;

endmodule

// File: doc/restoring_divider_ctrl.md
Name: restoring_divider_ctrl

Overview:
Multi-cycle unsigned restoring divider controller built around one shared ripple-subtractor datapath instance. It accepts a dividend/divisor pair on a start pulse and runs one subtract-and-restore step per clock for WIDTH cycles. It then presents quotient and remainder with a one-cycle done pulse. It sits beside the existing adder/subtractor lab blocks as the sequencing layer that reuses a single subtractor instead of an unrolled array.

Parameters:
WIDTH, 4, operand/quotient/remainder width in bits (legal range 2..16)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  asynchronous reset, active-high; clears all state immediately
start  input  1  request; sampled on rising clk, accepted only in IDLE or DONE
dividend  input  WIDTH  unsigned dividend, latched on accepted start
divisor  input  WIDTH  unsigned divisor, latched on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; results valid in that cycle and held afterwards
quotient  output  WIDTH  unsigned quotient
remainder  output  WIDTH  unsigned remainder
div_by_zero  output  1  set with done when the latched divisor was 0; held with results

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Internal registers (R, Q, D, count) are 0. Reset mid-RUN aborts with no done pulse.
- Internal registers:
  - R: partial remainder, WIDTH+1 bits
  - Q: dividend/quotient shift register, WIDTH bits
  - D: latched divisor, WIDTH bits
  - count: iteration counter, $clog2(WIDTH)+1 bits
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1 and divisor!=0: R=0, Q=dividend, D=divisor, count=WIDTH-1, div_by_zero=0, go to RUN.
- IDLE/DONE with start=1 and divisor==0: quotient=all ones, remainder=dividend, div_by_zero=1, go to DONE. done is high in the next cycle, so latency is 1.
- DONE with start=0: go to IDLE. done is high only in DONE.
- RUN, each cycle:
  - Form S = {R[WIDTH-1:0], Q[WIDTH-1]} (WIDTH+1 bits).
  - Compute diff = S - {1'b0, D} on the shared subtractor.
  - If no_borrow: R=diff and Q={Q[WIDTH-2:0],1}. Otherwise: R=S and Q={Q[WIDTH-2:0],0}.
  - If count==0: load quotient=next Q and remainder=next R[WIDTH-1:0], then go to DONE. Otherwise decrement count.
- Latency: start accepted at edge 0 gives WIDTH RUN cycles, with done high in the cycle after edge WIDTH (done visible WIDTH+1 cycles after start sampled). A new start in the DONE cycle is accepted, so back-to-back throughput is one result per WIDTH+1 cycles.
- start while busy (RUN) is ignored. Operand inputs may change freely after acceptance.
- quotient/remainder/div_by_zero change only on completion or reset. They hold their last value through IDLE and a subsequent RUN.
- Invariant: at the end, dividend == quotient*divisor + remainder and remainder < divisor (divisor != 0).
- Arithmetic: no_borrow is the subtractor carry-out from A + ~B + 1, with carry-in tied 1. no_borrow=1 iff A >= B. The MSB of R is always 0 after a step.

Decomposition:
- Shared package/include: FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default constant.
- One sub-module: sub_unit, a parameterized (WIDTH+1)-bit ripple subtractor.
  - Ports: a, b, diff, no_borrow.
  - Built from full-adder cells with inverted b and carry-in 1.
  - Purely combinational; instantiated once in the controller.
- The FSM, counter and shift registers stay in restoring_divider_ctrl.

Test Plan:
- 13/4 (WIDTH=4), start at cycle 0 -> busy cycles 1-4, done high in cycle 5 only, quotient=3, remainder=1, div_by_zero=0.
- 15/1 and 7/9 -> quotient=15/remainder=0 and quotient=0/remainder=7 respectively, each done after exactly WIDTH+1 cycles.
- 5/0 -> done one cycle after start, quotient=4'hF, remainder=5, div_by_zero=1, busy never asserted.
- 12/5 in progress, then start=1 with 9/3 during RUN -> ignored; result 2 r 2. Start 9/3 in the done cycle -> accepted, result 3 r 0 after WIDTH+1 more cycles.
- rst asserted mid-RUN (cycle 2, asynchronously between edges) -> outputs 0 immediately, no done pulse, and the next start 10/3 gives 3 r 1.
- Exhaustive sweep of all 256 pairs at WIDTH=4, plus a 500-pair random sweep at WIDTH=8 -> dividend == q*d + r, r < d, or the div_by_zero rule holds.
